gray_scan_mux: RTL
==================

// Module: gray_scan_mux
// PURPOSE
//  Registered, handshaked N:1 data selector; channel i carries Gray key i^(i>>1).
//  Manual mode: caller supplies a Gray-coded key. Scan mode: internal counter
//  round-robins channels in Gray order. One-entry output register with
//  valid/ready backpressure; feeds downstream stream consumers in the datapath.
// PARAMETERS
//  NR  4  number of input channels (2 <= NR <= 2**KW)
//  KW  2  key (select) width in bits
//  DW  8  data width per channel
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  mode       in   1      0 = manual (use sel), 1 = scan (internal counter)
//  sel        in   KW     Gray-coded channel key, manual mode only
//  inputs     in   NR*DW  channel data, channel i at [DW*i +: DW]
//  in_valid   in   NR     per-channel data valid
//  in_ready   out  NR     per-channel accept strobe (combinational)
//  out_data   out  DW     registered selected data
//  out_key    out  KW     registered Gray key of the channel captured
//  out_valid  out  1      output register holds data
//  out_ready  in   1      downstream accepts out_data this cycle
//  miss       out  1      registered: manual key matched no channel
// BEHAVIOUR
//  Reset (rst=1 at edge): out_data=0, out_key=0, out_valid=0, miss=0, scan idx=0,
//   prev-mode reg=0. rst wins over every other event incl. mid-transfer.
//  Gray decode of sel: b[KW-1]=g[KW-1]; b[k]=b[k+1]^g[k]. Index = b (binary).
//  Target: manual -> decoded index; scan -> idx (binary counter, KW bits).
//  hit = target < NR. Manual miss when !hit. Scan idx never exceeds NR-1.
//  slot_free = !out_valid | out_ready (single comb term, no bubble on accept).
//  load = slot_free & hit & in_valid[target].
//  in_ready[i] = load & (target==i); all other bits 0. One-hot or zero.
//  On load: out_data<=inputs[target], out_key<=target^(target>>1), out_valid<=1.
//  slot_free & !load: out_valid<=0 (out_data/out_key hold last value).
//  !slot_free: output register holds; sel/mode/inputs changes ignored.
//  Latency: 1 cycle from load to out_valid; throughput 1 word/cycle.
//  miss <= (mode==0) & !hit, updated every cycle regardless of out_ready.
//  Scan counter: advances when mode==1 & slot_free (load or empty-channel
//   skip alike); idx==NR-1 wraps to 0. Holds while stalled or in manual.
//  Mode 0->1 edge (prev-mode reg): idx forced to 0 that cycle, that cycle's
//   target is channel 0 (scan starts at key 0 deterministically).
//  Mode 1->0: idx held; next 0->1 restarts at 0 anyway.
//  Widths: key compare zero-extended to max(KW,clog2(NR)); no truncation.
// TESTING  (NR=4, KW=2, DW=8 unless noted; keys ch0..3 = 00,01,11,10)
//  1 rst=1 two cycles with all inputs valid -> out_valid=0, out_data=0,
//    out_key=0, miss=0, in_ready=0000.
//  2 manual sel=2'b11, in_valid=1111, ch2=8'hA5, out_ready=1 -> in_ready=0100
//    same cycle; next cycle out_data=A5, out_key=11, out_valid=1.
//  3 out_valid=1, out_ready=0 for 3 cycles while sel/inputs change -> out_data,
//    out_key stable, in_ready=0000; out_ready=1 -> new word next cycle.
//  4 scan, in_valid=1111, out_ready=1 -> out_key sequence 00,01,11,10,00
//    (wrap), out_valid=1 every cycle.
//  5 scan, in_valid=1101 -> keys 00, bubble (out_valid=0), 11, 10; mode
//    toggled 1->0->1 mid-sequence -> scan restarts at key 00.
//  6 NR=3, KW=2, manual sel=2'b10 (index 3) -> miss=1 next cycle, out_valid=0,
//    in_ready=000; sel=2'b01 -> miss=0, ch1 captured.

Source files
------------

// File: rtl/gray_scan_mux.sv
// gray_scan_mux: registered, handshaked NR:1 selector. Channel i is addressed
// by the Gray key i^(i>>1). In manual mode the caller supplies the key; in
// scan mode an internal counter visits channels round-robin in index order.
// The one-entry output register uses valid/ready backpressure.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-high
//   mode       0 = manual (use sel), 1 = scan (internal counter)
//   sel        Gray-coded channel key, manual mode only
//   inputs     channel data, channel i at [DW*i +: DW]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept strobe (combinational, one-hot or zero)
//   out_data   registered selected data
//   out_key    registered Gray key of the captured channel
//   out_valid  output register holds data
//   out_ready  downstream accepts out_data this cycle
//   miss       registered: manual key matched no channel
module gray_scan_mux #(
  parameter int unsigned NR = 4,
  parameter int unsigned KW = 2,
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [KW-1:0]    sel,
  input  logic [NR*DW-1:0] inputs,
  input  logic [NR-1:0]    in_valid,
  output logic [NR-1:0]    in_ready,
  output logic [DW-1:0]    out_data,
  output logic [KW-1:0]    out_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             miss
);

  // Compare width holds both any key value and the constant NR itself.
  localparam int unsigned CW   = (KW > $clog2(NR)) ? KW : $clog2(NR);
  localparam int unsigned CMPW = CW + 1;

  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] key_q, key_d;
  logic          valid_q, valid_d;
  logic          miss_q, miss_d;
  logic [KW-1:0] idx_q, idx_d;
  logic          prev_mode_q, prev_mode_d;

  logic [KW-1:0] dec_idx;
  logic [KW-1:0] scan_idx;
  logic [KW-1:0] target;
  logic          hit;
  logic          slot_free;
  logic          load;
  logic          sel_valid;
  logic [DW-1:0] sel_data;

  // Gray to binary: bit k is the XOR of all key bits at or above k.
  always_comb begin
    dec_idx = '0;
    for (int unsigned k = 0; k < KW; k++) begin
      dec_idx[k] = ^(sel >> k);
    end
  end

  // A fresh entry into scan mode always starts at channel 0.
  assign scan_idx  = (mode && !prev_mode_q) ? '0 : idx_q;
  assign target    = mode ? scan_idx : dec_idx;
  assign hit       = CMPW'(target) < CMPW'(NR);
  assign slot_free = !valid_q || out_ready;

  // Channel data/valid mux for the current target.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (target == KW'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = inputs[DW*i +: DW];
      end
    end
  end

  // Nothing is accepted while reset is asserted.
  assign load = !rst && slot_free && hit && sel_valid;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      in_ready[i] = load && (target == KW'(i));
    end
  end

  // Next-state for the output register, miss flag and scan counter.
  always_comb begin
    data_d      = data_q;
    key_d       = key_q;
    valid_d     = valid_q;
    miss_d      = !mode && !hit;
    idx_d       = idx_q;
    prev_mode_d = mode;

    if (load) begin
      data_d  = sel_data;
      key_d   = target ^ (target >> 1);
      valid_d = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    // Scan counter steps on every free slot, whether or not the channel loaded.
    if (mode) begin
      if (slot_free) begin
        idx_d = (scan_idx == KW'(NR - 1)) ? '0 : scan_idx + KW'(1);
      end else begin
        idx_d = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      key_q       <= '0;
      valid_q     <= 1'b0;
      miss_q      <= 1'b0;
      idx_q       <= '0;
      prev_mode_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      miss_q      <= miss_d;
      idx_q       <= idx_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  assign out_data  = data_q;
  assign out_key   = key_q;
  assign out_valid = valid_q;
  assign miss      = miss_q;

endmodule
